// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control sequencer: opcodes, ALU codes,
// state encoding and the opcode classifier.
package cpu_ctrl_pkg;

   localparam int unsigned OP_W      = 5;
   localparam int unsigned ALU_W     = 5;
   localparam int unsigned NUM_REGS  = 16;
   localparam int unsigned REG_IDX_W = 4;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
   localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
   localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
   localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11000;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11001;

   localparam logic [ALU_W-1:0] ALU_ADD = 5'd0;
   localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;
   localparam logic [ALU_W-1:0] ALU_AND = 5'd2;
   localparam logic [ALU_W-1:0] ALU_OR  = 5'd3;
   localparam logic [ALU_W-1:0] ALU_SHR = 5'd4;
   localparam logic [ALU_W-1:0] ALU_SHL = 5'd5;
   localparam logic [ALU_W-1:0] ALU_ROR = 5'd6;
   localparam logic [ALU_W-1:0] ALU_ROL = 5'd7;
   localparam logic [ALU_W-1:0] ALU_MUL = 5'd8;
   localparam logic [ALU_W-1:0] ALU_DIV = 5'd9;
   localparam logic [ALU_W-1:0] ALU_NEG = 5'd10;
   localparam logic [ALU_W-1:0] ALU_NOT = 5'd11;

   typedef enum logic [3:0] {
      S_FETCH0, S_FETCH1, S_MEMRD_I, S_FETCH2, S_DECODE,
      S_EX0, S_EX1, S_EX2, S_EX3, S_MEMRD_D, S_EX4, S_MEMWR, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      C_RR, C_IMM, C_UNARY, C_MULDIV, C_LD, C_ST, C_NOP, C_HALT, C_ILLEGAL
   } iclass_t;

   function automatic iclass_t classify(input logic [OP_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: return C_RR;
         OP_ADDI, OP_ANDI, OP_ORI:       return C_IMM;
         OP_NEG, OP_NOT:                 return C_UNARY;
         OP_MUL, OP_DIV:                 return C_MULDIV;
         OP_LD:                          return C_LD;
         OP_ST:                          return C_ST;
         OP_NOP:                         return C_NOP;
         OP_HALT:                        return C_HALT;
         default:                        return C_ILLEGAL;
      endcase
   endfunction

   function automatic logic [ALU_W-1:0] alu_op(input logic [OP_W-1:0] op);
      case (op)
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR, OP_ORI:   return ALU_OR;
         OP_SHR:          return ALU_SHR;
         OP_SHL:          return ALU_SHL;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         default:         return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// Register-field to one-hot strobe decoder with enable.
module reg_select_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] sel,
   input  logic                 en,
   output logic [NUM_REGS-1:0]  onehot_c
);

   always_comb begin
      onehot_c = '0;
      if (en) onehot_c[sel] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle hardwired control unit: fetch, decode and execute sequencing
// for the bus datapath. Strobes are a Moore decode of state and ir fields.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT   = 16,
   parameter int unsigned RESET_PC_HOLD = 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic [31:0]      ir,
   input  logic             mem_done,
   output logic [15:0]      Rin,
   output logic [15:0]      Rout,
   output logic             PCout,
   output logic             PCin,
   output logic             IRin,
   output logic             MARin,
   output logic             MDRin,
   output logic             MDRout,
   output logic             Yin,
   output logic             IncPC,
   output logic             ALUin,
   output logic             ZMuxEnable,
   output logic             ZSelect,
   output logic             ZMuxOut,
   output logic             HIin,
   output logic             LOin,
   output logic             CSignout,
   output logic             Read,
   output logic             Write,
   output logic [ALU_W-1:0] aluControl,
   output logic             run,
   output logic             err
);

   localparam int unsigned CNT_W  = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned HOLD_W = $clog2(RESET_PC_HOLD + 2);

   state_t                 state;
   iclass_t                cls;
   logic [CNT_W-1:0]       wait_cnt;
   logic [HOLD_W-1:0]      hold_cnt;
   logic [REG_IDX_W-1:0]   ra, rb, rc, rin_sel, rout_sel;
   logic                   rin_en, rout_en, mem_wait, mem_expired, active;
   logic                   unused_ir;

   assign cls         = classify(ir[31:27]);
   assign ra          = ir[26:23];
   assign rb          = ir[22:19];
   assign rc          = ir[18:15];
   assign unused_ir   = ^ir[14:0];
   assign mem_wait    = state inside {S_MEMRD_I, S_MEMRD_D, S_MEMWR};
   assign mem_expired = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
   assign active      = run & ~clear;

   // Sequencer state, memory wait counter, post-reset hold, run and sticky err.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state    <= S_FETCH0;
         err      <= 1'b0;
         run      <= 1'b0;
         wait_cnt <= '0;
         hold_cnt <= HOLD_W'(RESET_PC_HOLD);
      end else if (hold_cnt != '0) begin
         hold_cnt <= hold_cnt - HOLD_W'(1);
         run      <= (hold_cnt == HOLD_W'(1));
         state    <= S_FETCH0;
      end else begin
         if (state != S_HALT) run <= 1'b1;
         if (mem_wait && !mem_done) begin
            // mem_done on the last allowed cycle takes the other branch
            if (mem_expired) begin
               err      <= 1'b1;
               wait_cnt <= '0;
               state    <= S_FETCH0;
            end else begin
               wait_cnt <= wait_cnt + CNT_W'(1);
            end
         end else begin
            wait_cnt <= '0;
            case (state)
               S_FETCH0:  state <= S_FETCH1;
               S_FETCH1:  state <= S_MEMRD_I;
               S_MEMRD_I: state <= S_FETCH2;
               S_FETCH2:  state <= S_DECODE;
               S_DECODE: begin
                  case (cls)
                     C_UNARY: state <= S_EX1;
                     C_NOP:   state <= S_FETCH0;
                     C_HALT: begin
                        state <= S_HALT;
                        run   <= 1'b0;
                     end
                     C_ILLEGAL: begin
                        err   <= 1'b1;
                        state <= S_FETCH0;
                     end
                     default: state <= S_EX0;
                  endcase
               end
               S_EX0: state <= S_EX1;
               S_EX1: state <= S_EX2;
               S_EX2: begin
                  case (cls)
                     C_MULDIV, C_ST: state <= S_EX3;
                     C_LD:           state <= S_MEMRD_D;
                     default:        state <= S_FETCH0;
                  endcase
               end
               S_EX3:     state <= (cls == C_ST) ? S_MEMWR : S_FETCH0;
               S_MEMRD_D: state <= S_EX4;
               S_HALT:    state <= S_HALT;
               default:   state <= S_FETCH0;
            endcase
         end
      end
   end

   // Strobe decode; everything is forced idle while clear, hold or halt.
   always_comb begin
      PCout      = 1'b0;
      PCin       = 1'b0;
      IRin       = 1'b0;
      MARin      = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      Yin        = 1'b0;
      IncPC      = 1'b0;
      ALUin      = 1'b0;
      ZMuxEnable = 1'b0;
      ZSelect    = 1'b0;
      ZMuxOut    = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      CSignout   = 1'b0;
      Read       = 1'b0;
      Write      = 1'b0;
      aluControl = ALU_ADD;
      rin_en     = 1'b0;
      rin_sel    = ra;
      rout_en    = 1'b0;
      rout_sel   = rb;
      if (active) begin
         case (state)
            S_FETCH0: begin
               PCout = 1'b1;
               MARin = 1'b1;
               IncPC = 1'b1;
               ALUin = 1'b1;
            end
            S_FETCH1: begin
               ZMuxEnable = 1'b1;
               ZMuxOut    = 1'b1;
               PCin       = 1'b1;
            end
            S_MEMRD_I, S_MEMRD_D: begin
               Read  = 1'b1;
               MDRin = 1'b1;
            end
            S_FETCH2: begin
               MDRout = 1'b1;
               IRin   = 1'b1;
            end
            S_EX0: begin
               Yin      = 1'b1;
               rout_en  = 1'b1;
               rout_sel = (cls == C_MULDIV) ? ra : rb;
            end
            S_EX1: begin
               ALUin = 1'b1;
               case (cls)
                  C_RR: begin
                     rout_en    = 1'b1;
                     rout_sel   = rc;
                     aluControl = alu_op(ir[31:27]);
                  end
                  C_IMM: begin
                     CSignout   = 1'b1;
                     aluControl = alu_op(ir[31:27]);
                  end
                  C_UNARY, C_MULDIV: begin
                     rout_en    = 1'b1;
                     aluControl = alu_op(ir[31:27]);
                  end
                  C_LD, C_ST: CSignout = 1'b1;
                  default: ;
               endcase
            end
            S_EX2: begin
               ZMuxEnable = 1'b1;
               case (cls)
                  C_MULDIV: LOin = 1'b1;
                  C_LD, C_ST: begin
                     ZMuxOut = 1'b1;
                     MARin   = 1'b1;
                  end
                  default: begin
                     ZMuxOut = 1'b1;
                     rin_en  = 1'b1;
                  end
               endcase
            end
            S_EX3: begin
               if (cls == C_MULDIV) begin
                  ZMuxEnable = 1'b1;
                  ZSelect    = 1'b1;
                  HIin       = 1'b1;
               end else begin
                  rout_en  = 1'b1;
                  rout_sel = ra;
                  MDRin    = 1'b1;
               end
            end
            S_EX4: begin
               MDRout = 1'b1;
               rin_en = 1'b1;
            end
            S_MEMWR: Write = 1'b1;
            default: ;
         endcase
      end
   end

   reg_select_decoder u_rin_dec (
      .sel      (rin_sel),
      .en       (rin_en),
      .onehot_c (Rin)
   );

   reg_select_decoder u_rout_dec (
      .sel      (rout_sel),
      .en       (rout_en),
      .onehot_c (Rout)
   );

endmodule
